alu_writeback_stage: RTL and testbench
======================================

// Module: alu_writeback_stage
// PURPOSE
//  Stage directly downstream of the ALU. Captures alu_result plus instruction tag in a 2-entry buffer.
//  Retires one entry per cycle into an 8x19 register file, or resolves BEQ/BNE into a branch pulse.
//  Holds the MAC accumulator. Serves two combinational read ports back to operand fetch.
// PARAMETERS
//  DATA_W  19  datapath width (matches ALU op1/op2/alu_result)
//  OPC_W   5   opcode width
//  REG_N   8   register file depth
//  ADDR_W  3   register address width, clog2(REG_N)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous reset, active-high
//  in_valid     in   1       ALU result valid
//  in_ready     out  1       stage can accept (combinational)
//  in_opcode    in   OPC_W   opcode that produced in_result
//  in_rd        in   ADDR_W  destination register
//  in_result    in   DATA_W  alu_result
//  in_target    in   DATA_W  branch target (used for BEQ/BNE only)
//  wb_hold      in   1       1 = do not retire this cycle
//  flush        in   1       discard all buffered entries
//  rs1_addr     in   ADDR_W  read port 1 address
//  rs1_data     out  DATA_W  read port 1 data (combinational)
//  rs2_addr     in   ADDR_W  read port 2 address
//  rs2_data     out  DATA_W  read port 2 data (combinational)
//  acc_out      out  DATA_W  MAC accumulator, fed back to ALU
//  br_taken     out  1       registered one-cycle branch pulse
//  br_target    out  DATA_W  target, valid while br_taken=1
//  err_illegal  out  1       registered one-cycle pulse, undefined opcode retired
// BEHAVIOUR
//  Reset (async, immediate): buffer EMPTY, all regs 0, acc_out 0, br_taken 0, br_target 0, err_illegal 0.
//  Buffer FSM, states EMPTY/ONE/FULL. Entry = {opcode, rd, result, target}. FIFO order.
//  - in_ready = (state != FULL). Push when in_valid && in_ready.
//  - retire = (state != EMPTY) && !wb_hold && !flush. Head retires at the clock edge.
//  - Push and retire in the same cycle: state unchanged. Data order is preserved.
//  - In FULL, in_ready=0 even if the head retires that cycle. There is no same-cycle refill.
//  - flush: next state EMPTY. No retire, and a same-cycle push is dropped. Priority: rst > flush > push/retire.
//  Latency: entry pushed at edge N retires at edge N+1 at the earliest (EMPTY, wb_hold=0).
//  Retire action, by head opcode:
//  - 01111 BEQ / 10000 BNE: no reg write. If result[0]=1, br_taken=1 and br_target=target for one cycle. Otherwise br_taken=0.
//  - 01000 MAC: regs[rd] <= result and acc_out <= result.
//  - 00000..01101 (except 01000): regs[rd] <= result.
//  - 01110, 10001..11111: no write, err_illegal=1 for one cycle.
//  - rd=0: write suppressed. r0 reads 0 always.
//  - br_taken and err_illegal are 0 in every cycle without a qualifying retire.
//  Read ports: rsX_data = regs[rsX_addr], with bypass. If this cycle retires a write to the same nonzero
//   address, the read returns the retiring result. rsX_addr=0 returns 0.
//  Widths: all data DATA_W and unsigned. No arithmetic in this stage. Results are stored unmodified.
//  rst mid-operation: buffered entries are lost and no pulse is emitted.
// TESTING
//  1 rst, then push ADD rd=3 result=19'd42, wb_hold=0 -> after next edge rs1_addr=3 reads 42; in_ready stays 1.
//  2 wb_hold=1, push 3 entries back-to-back -> 2 accepted, in_ready=0 on 3rd; release hold -> rd writes in order, 1/cycle.
//  3 push BEQ result=1 target=19'h00100, then BNE result=0 -> br_taken=1 with target 0x100 for exactly 1 cycle, then 0.
//  4 push MAC rd=2 result=19'd7 -> acc_out=7 and r2=7; push opcode 11111 -> err_illegal pulse, no reg changes.
//  5 FULL buffer + flush with in_valid=1 -> EMPTY next cycle, no writes or pulses; push rd=0 result=5 -> r0 reads 0.
//  6 assert rst while FULL mid-cycle -> outputs 0 immediately, no writes after release; check retire/read bypass same-cycle.

Source files
------------

// File: rtl/alu_writeback_stage_if.sv
// ALU -> writeback handshake bus: one result plus its instruction tag per transfer.
interface alu_writeback_stage_if #(
  parameter int DATA_W = 19,
  parameter int OPC_W  = 5,
  parameter int ADDR_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [OPC_W-1:0]  in_opcode;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] in_result;
  logic [DATA_W-1:0] in_target;

  modport master (output in_valid, in_opcode, in_rd, in_result, in_target, input in_ready);
  modport slave  (input in_valid, in_opcode, in_rd, in_result, in_target, output in_ready);
endinterface

// File: rtl/alu_writeback_stage.sv
// Writeback stage: 2-entry result buffer, register file with bypassed read ports,
// MAC accumulator and branch/illegal-opcode pulses.
module alu_writeback_stage #(
  parameter int DATA_W = 19,
  parameter int OPC_W  = 5,
  parameter int REG_N  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  alu_writeback_stage_if.slave in_if,
  input  logic              wb_hold,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rs1_addr,
  output logic [DATA_W-1:0] rs1_data,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] acc_out,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
  output logic              err_illegal
);
  localparam logic [OPC_W-1:0] OP_MAC     = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_ALU_MAX = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_ILL     = OPC_W'(14);
  localparam logic [OPC_W-1:0] OP_BEQ     = OPC_W'(15);
  localparam logic [OPC_W-1:0] OP_BNE     = OPC_W'(16);

  typedef struct packed {
    logic [OPC_W-1:0]  opc;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] tgt;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t                        state;
  entry_t [1:0]                  ent;   // ent[0] is the head
  logic   [REG_N-1:0][DATA_W-1:0] regs;
  entry_t                        head, new_e;
  logic                          push, retire, head_wr, head_br, head_ill;
  logic   [1:0][ADDR_W-1:0]      rd_addr;
  logic   [1:0][DATA_W-1:0]      rd_data;

  assign head  = ent[0];
  assign new_e = '{opc: in_if.in_opcode, rd: in_if.in_rd, res: in_if.in_result, tgt: in_if.in_target};

  // FULL never accepts, even when the head leaves this cycle.
  assign in_if.in_ready = (state != FULL);
  assign push    = in_if.in_valid && in_if.in_ready && !flush;
  assign retire  = (state != EMPTY) && !wb_hold && !flush;
  assign head_wr = retire && (head.opc <= OP_ALU_MAX) && (head.rd != '0);
  assign head_br = (head.opc == OP_BEQ) || (head.opc == OP_BNE);
  assign head_ill = (head.opc == OP_ILL) || (head.opc > OP_BNE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      ent         <= '0;
      regs        <= '0;
      acc_out     <= '0;
      br_taken    <= 1'b0;
      br_target   <= '0;
      err_illegal <= 1'b0;
    end else begin
      br_taken    <= 1'b0;
      err_illegal <= 1'b0;
      if (flush) begin
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: if (push) begin ent[0] <= new_e; state <= ONE; end
          ONE: begin
            if (push && retire) ent[0] <= new_e;
            else if (push) begin ent[1] <= new_e; state <= FULL; end
            else if (retire) state <= EMPTY;
          end
          FULL: if (retire) begin ent[0] <= ent[1]; state <= ONE; end
          default: state <= EMPTY;
        endcase
        if (retire) begin
          if (head_wr) regs[head.rd] <= head.res;
          if (head.opc == OP_MAC) acc_out <= head.res;
          if (head_br && head.res[0]) begin
            br_taken  <= 1'b1;
            br_target <= head.tgt;
          end
          if (head_ill) err_illegal <= 1'b1;
        end
      end
    end
  end

  // Read ports see the value retiring this cycle; r0 is hardwired zero.
  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;
  for (genvar p = 0; p < 2; p++) begin : g_rd
    assign rd_data[p] = (rd_addr[p] == '0)                 ? '0 :
                        (head_wr && head.rd == rd_addr[p]) ? head.res :
                                                             regs[rd_addr[p]];
  end
  assign rs1_data = rd_data[0];
  assign rs2_data = rd_data[1];
endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: expected writes queued at push, checked at retire.
module tb_alu_writeback_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_hold, flush;
  logic [2:0]  rs1_addr, rs2_addr;
  logic [18:0] rs1_data, rs2_data, acc_out, br_target;
  logic        br_taken, err_illegal;
  int          n_chk = 0, n_err = 0;

  typedef struct {logic [2:0] rd; logic [18:0] val;} wr_t;
  wr_t exp_q[$];

  alu_writeback_stage_if #(.DATA_W(19), .OPC_W(5), .ADDR_W(3)) bus();

  alu_writeback_stage #(.DATA_W(19), .OPC_W(5), .REG_N(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .in_if(bus), .wb_hold(wb_hold), .flush(flush),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
    .acc_out(acc_out), .br_taken(br_taken), .br_target(br_target), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one transfer for the coming edge; queue an expected write if it will be accepted.
  task automatic drive(input logic [4:0] op, input logic [2:0] rd, input logic [18:0] res,
                       input logic [18:0] tgt, input logic exp_wr);
    bus.in_valid = 1'b1; bus.in_opcode = op; bus.in_rd = rd;
    bus.in_result = res; bus.in_target = tgt;
    #1;
    if (exp_wr && bus.in_ready && !flush) exp_q.push_back('{rd, res});
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic rd1(input logic [2:0] a, input string tag, input logic [18:0] exp);
    rs1_addr = a; #1; chk(tag, rs1_data, exp);
  endtask

  task automatic rd2(input logic [2:0] a, input string tag, input logic [18:0] exp);
    rs2_addr = a; #1; chk(tag, rs2_data, exp);
  endtask

  // One retire per cycle, in push order.
  task automatic drain();
    wr_t w;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
      step();
      w = exp_q.pop_front();
      rd1(w.rd, "wb_order", w.val);
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; wb_hold = 1'b0; flush = 1'b0; rs1_addr = '0; rs2_addr = '0;
    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_result = '0; bus.in_target = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_acc", acc_out, 0);
    chk("rst_br", br_taken, 0);
    chk("rst_tgt", br_target, 0);
    chk("rst_err", err_illegal, 0);
    rd1(3'd3, "rst_r3", 0);
    rst = 1'b0;

    // 1: single ADD, bypass then register
    drive(5'b00000, 3'd3, 19'd42, 19'd0, 1'b1);
    chk("t1_ready", bus.in_ready, 1);
    step(); idle();
    chk("t1_ready_after", bus.in_ready, 1);
    rd1(3'd3, "t1_bypass", 19'd42);
    drain();

    // 2: hold, fill to FULL, third push refused, then ordered drain
    wb_hold = 1'b1;
    drive(5'b00001, 3'd1, 19'd11, 19'd0, 1'b1); chk("t2_rdy0", bus.in_ready, 1); step();
    drive(5'b00011, 3'd4, 19'd22, 19'd0, 1'b1); chk("t2_rdy1", bus.in_ready, 1); step();
    drive(5'b00101, 3'd5, 19'd33, 19'd0, 1'b1); chk("t2_rdy_full", bus.in_ready, 0); step();
    idle(); wb_hold = 1'b0;
    rd1(3'd1, "t2_bypass_head", 19'd11);
    rd2(3'd4, "t2_second_not_yet", 19'd0);
    drain();
    rd2(3'd5, "t2_dropped_r5", 19'd0);

    // 3: taken BEQ then not-taken BNE
    drive(5'b01111, 3'd6, 19'd1, 19'h00100, 1'b0); step();
    drive(5'b10000, 3'd6, 19'd0, 19'h00055, 1'b0);
    chk("t3_br_before", br_taken, 0);
    step(); idle();
    chk("t3_br_taken", br_taken, 1);
    chk("t3_br_target", br_target, 19'h00100);
    step();
    chk("t3_br_bne_nt", br_taken, 0);
    step();
    chk("t3_br_quiet", br_taken, 0);
    rd1(3'd6, "t3_no_write", 19'd0);

    // 4: MAC updates acc and reg; illegal opcodes pulse and do not write
    drive(5'b01000, 3'd2, 19'd7, 19'd0, 1'b0); step(); idle(); step();
    chk("t4_acc", acc_out, 19'd7);
    rd1(3'd2, "t4_r2", 19'd7);
    drive(5'b11111, 3'd2, 19'd99, 19'd0, 1'b0); step(); idle();
    chk("t4_err_pre", err_illegal, 0);
    step();
    chk("t4_err_pulse", err_illegal, 1);
    rd1(3'd2, "t4_r2_kept", 19'd7);
    step();
    chk("t4_err_clear", err_illegal, 0);
    drive(5'b01110, 3'd7, 19'd5, 19'd0, 1'b0); step(); idle(); step();
    chk("t4_err_01110", err_illegal, 1);
    rd1(3'd7, "t4_r7_kept", 19'd0);
    chk("t4_acc_kept", acc_out, 19'd7);

    // 5: flush from FULL and from ONE drops everything including same-cycle push
    wb_hold = 1'b1;
    drive(5'b00000, 3'd1, 19'd111, 19'd0, 1'b0); step();
    drive(5'b01111, 3'd4, 19'd1, 19'h00077, 1'b0); step();
    flush = 1'b1;
    drive(5'b00000, 3'd5, 19'd333, 19'd0, 1'b0); step();
    flush = 1'b0; idle(); wb_hold = 1'b0;
    chk("t5_ready", bus.in_ready, 1);
    step(); step();
    chk("t5_no_br", br_taken, 0);
    rd1(3'd1, "t5_r1", 19'd11);
    rd2(3'd5, "t5_r5", 19'd0);
    wb_hold = 1'b1;
    drive(5'b00000, 3'd5, 19'd333, 19'd0, 1'b0); step();
    flush = 1'b1;
    drive(5'b00000, 3'd6, 19'd444, 19'd0, 1'b0); step();
    flush = 1'b0; idle(); wb_hold = 1'b0;
    step(); step();
    rd1(3'd5, "t5_r5_one", 19'd0);
    rd2(3'd6, "t5_r6_one", 19'd0);
    drive(5'b00000, 3'd0, 19'd5, 19'd0, 1'b0); step(); idle();
    rd1(3'd0, "t5_r0_bypass", 19'd0);
    step();
    rd1(3'd0, "t5_r0", 19'd0);

    // 6: async reset mid-cycle while FULL, then bypass vs hold
    wb_hold = 1'b1;
    drive(5'b00000, 3'd1, 19'd77, 19'd0, 1'b0); step();
    drive(5'b01000, 3'd4, 19'd88, 19'd0, 1'b0); step();
    idle(); wb_hold = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_ready", bus.in_ready, 1);
    chk("t6_rst_acc", acc_out, 0);
    chk("t6_rst_tgt", br_target, 0);
    rd1(3'd1, "t6_rst_r1", 19'd0);
    step();
    rst = 1'b0;
    step(); step();
    rd1(3'd1, "t6_r1_after", 19'd0);
    rd2(3'd4, "t6_r4_after", 19'd0);
    chk("t6_acc_after", acc_out, 0);
    chk("t6_err_after", err_illegal, 0);
    drive(5'b00010, 3'd3, 19'd55, 19'd0, 1'b0); step(); idle();
    rd1(3'd3, "t6_bypass_p1", 19'd55);
    rd2(3'd3, "t6_bypass_p2", 19'd55);
    rd2(3'd2, "t6_other_addr", 19'd0);
    step();
    rd2(3'd3, "t6_r3", 19'd55);
    wb_hold = 1'b1;
    drive(5'b00010, 3'd3, 19'd66, 19'd0, 1'b0); step(); idle();
    rd1(3'd3, "t6_hold_nobypass", 19'd55);
    wb_hold = 1'b0;
    rd1(3'd3, "t6_release_bypass", 19'd66);
    step();
    rd2(3'd3, "t6_r3_new", 19'd66);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
